output_port_controller: RTL and testbench
=========================================

Name: output_port_controller

Overview:
- Per-output-port arbiter and forwarder for the mesh NoC router. One instance per output direction (East, North, West, South, Local); it sits directly downstream of the five input port controllers.
- Each input controller raises its request bit for this port. The block grants one requester round-robin, registers that requester's packet, and drives it onto the outgoing link with a valid/ready handshake.
- When the link accepts the packet, the block returns a one-cycle grant to the winning input controller so it can release its request.

Parameters:
- dataWidth, 32, packet width in bits.
- numPorts, 5, number of requesting input controllers. Fixed at 5 (E=0, N=1, W=2, S=3, Local=4); other values are unsupported.
- cntWidth, 16, width of the forwarded-packet counter.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- reqIn  input  5  request bit i comes from input controller i (its request bit for this port).
- packetIn  input  5*dataWidth  flattened packets; slice i = bits [(i+1)*dataWidth-1 : i*dataWidth] comes from input controller i.
- gntOut  output  5  one-hot grant pulse to input controller i.
- packetOut  output  dataWidth  registered packet to the link / next router FIFO.
- validOut  output  1  packetOut is valid.
- readyIn  input  1  downstream can accept this cycle (FIFO not full).
- busy  output  1  high whenever state is not IDLE.
- pktCount  output  cntWidth  number of packets accepted downstream.

Behaviour:
- Reset (synchronous, reset=1 at a rising edge) sets:
  - state=IDLE, gntOut=0, validOut=0, packetOut=0, busy=0.
  - rrPtr=0, winner=0, pktCount=0.
- Reset overrides everything, including a transfer in progress. No grant is issued for an aborted transfer.
- FSM states are IDLE, SEND, GRANT.
- IDLE:
  - If reqIn==0, remain in IDLE.
  - Otherwise pick the winner: the first set bit of reqIn searching rrPtr, rrPtr+1, ... mod 5.
  - On that edge: register winner, register packetOut = winner's packetIn slice, set validOut=1, go to SEND.
  - Latency is one cycle from a request being visible to validOut high.
- SEND:
  - Hold validOut=1 and packetOut stable.
  - packetIn and reqIn are ignored, including a request that drops early.
  - When readyIn=1 at an edge (handshake): validOut<=0, gntOut<=one-hot(winner), pktCount<=pktCount+1 (wraps modulo 2^cntWidth), go to GRANT.
  - When readyIn=0, stay in SEND indefinitely (no timeout).
- GRANT:
  - gntOut is high for exactly this one cycle.
  - At the end of this cycle: gntOut<=0, rrPtr<=(winner+1) mod 5, go to IDLE.
  - The granted controller drops its request on the same edge, so a stale request is never re-arbitrated.
- Throughput and overlap:
  - Minimum 3 cycles per packet.
  - At most one packet is in flight.
  - gntOut and validOut are never high together.
- Arbitration rules:
  - Requests arriving during SEND or GRANT wait; they are considered only in IDLE.
  - Simultaneous requests are resolved purely by rrPtr.
  - rrPtr changes only after a completed handshake.
  - When winner=4, rrPtr wraps from 4 to 0.
- busy = (state != IDLE).

Test Plan:
- Reset check: assert reset mid-SEND with validOut=1 -> next cycle validOut=0, gntOut=0, pktCount=0, rrPtr=0; no grant is ever issued for the aborted packet.
- Single requester: reqIn=5'b00100, slice2=32'hA5A5_0001, readyIn=1 -> validOut high one cycle after the request with packetOut=32'hA5A5_0001; then gntOut=5'b00100 for exactly one cycle; pktCount=1.
- Round-robin fairness: all five requesters held high and re-raised after each grant, readyIn=1 -> grant order 0,1,2,3,4,0; each packet spaced 3 cycles apart.
- Backpressure: readyIn=0 for 10 cycles during SEND while packetIn of the winner changes -> validOut stays 1, packetOut unchanged, gntOut=0; readyIn=1 -> grant follows on the next cycle.
- Simultaneous requests after a pointer move: grant port 3 first (rrPtr becomes 4), then reqIn=5'b10001 -> port 4 wins before port 0.
- Counter wrap: preload by running 65535 transfers (or force pktCount=16'hFFFF) -> next handshake yields pktCount=0.

Source files
------------

// File: rtl/output_port_controller.sv
// Output-port arbiter/forwarder for one mesh NoC router direction.
// Picks one requesting input round-robin, holds its packet on the link until accepted, then pulses a grant back.
module output_port_controller #(
  parameter int unsigned dataWidth = 32,
  parameter int unsigned numPorts  = 5,
  parameter int unsigned cntWidth  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [numPorts-1:0]           reqIn,
  input  logic [numPorts*dataWidth-1:0] packetIn,
  output logic [numPorts-1:0]           gntOut,
  output logic [dataWidth-1:0]          packetOut,
  output logic                          validOut,
  input  logic                          readyIn,
  output logic                          busy,
  output logic [cntWidth-1:0]           pktCount
);

  localparam int unsigned PtrW = 3;
  localparam int unsigned SumW = PtrW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    GRANT = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [PtrW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0]       winner_q, winner_d;
  logic [numPorts-1:0]   gnt_q, gnt_d;
  logic [dataWidth-1:0]  packet_q, packet_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic [cntWidth-1:0]   pkt_count_q, pkt_count_d;

  logic                  arb_found;
  logic [PtrW-1:0]       arb_idx;
  logic [SumW-1:0]       cand;

  // Round-robin search: first set request bit starting at rr_ptr_q, wrapping mod numPorts.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < numPorts; k++) begin
      cand = SumW'(rr_ptr_q) + SumW'(k);
      if (cand >= SumW'(numPorts)) begin
        cand = cand - SumW'(numPorts);
      end
      if (!arb_found && reqIn[cand[PtrW-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = cand[PtrW-1:0];
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    winner_d    = winner_q;
    gnt_d       = gnt_q;
    packet_d    = packet_q;
    valid_d     = valid_q;
    pkt_count_d = pkt_count_q;

    unique case (state_q)
      IDLE: begin
        if (arb_found) begin
          winner_d = arb_idx;
          packet_d = packetIn[32'(arb_idx) * dataWidth +: dataWidth];
          valid_d  = 1'b1;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (readyIn) begin
          valid_d          = 1'b0;
          gnt_d            = '0;
          gnt_d[winner_q]  = 1'b1;
          pkt_count_d      = pkt_count_q + cntWidth'(1);
          state_d          = GRANT;
        end
      end
      GRANT: begin
        gnt_d    = '0;
        rr_ptr_d = (winner_q == PtrW'(numPorts - 1)) ? '0 : winner_q + PtrW'(1);
        state_d  = IDLE;
      end
      default: begin
        gnt_d   = '0;
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State register; reset aborts any transfer in flight without granting it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      winner_q    <= '0;
      gnt_q       <= '0;
      packet_q    <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      winner_q    <= winner_d;
      gnt_q       <= gnt_d;
      packet_q    <= packet_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  assign gntOut    = gnt_q;
  assign packetOut = packet_q;
  assign validOut  = valid_q;
  assign busy      = busy_q;
  assign pktCount  = pkt_count_q;

endmodule

// File: tb/tb_output_port_controller.sv
// Directed self-checking bench for output_port_controller.
// A second instance with a 3-bit counter shares all stimulus so counter wrap is reachable quickly.
module tb_output_port_controller;

  localparam int unsigned DW = 32;
  localparam int unsigned NP = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic [NP-1:0]   req_in;
  logic [NP*DW-1:0] packet_in;
  logic            ready_in;

  logic [NP-1:0]   gnt_out;
  logic [DW-1:0]   packet_out;
  logic            valid_out;
  logic            busy;
  logic [15:0]     pkt_count;

  logic [NP-1:0]   s_gnt_out;
  logic [DW-1:0]   s_packet_out;
  logic            s_valid_out;
  logic            s_busy;
  logic [2:0]      s_pkt_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  output_port_controller #(.dataWidth(DW), .numPorts(NP), .cntWidth(16)) dut (
    .clk(clk), .reset(reset), .reqIn(req_in), .packetIn(packet_in),
    .gntOut(gnt_out), .packetOut(packet_out), .validOut(valid_out),
    .readyIn(ready_in), .busy(busy), .pktCount(pkt_count)
  );

  output_port_controller #(.dataWidth(DW), .numPorts(NP), .cntWidth(3)) dut_small (
    .clk(clk), .reset(reset), .reqIn(req_in), .packetIn(packet_in),
    .gntOut(s_gnt_out), .packetOut(s_packet_out), .validOut(s_valid_out),
    .readyIn(ready_in), .busy(s_busy), .pktCount(s_pkt_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic set_slice(input int unsigned idx, input logic [DW-1:0] val);
    packet_in[idx*DW +: DW] = val;
  endtask

  task automatic test_reset();
    req_in = '0; ready_in = 1'b0; packet_in = '0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checks++;
    if (gnt_out !== 5'b0 || valid_out !== 1'b0 || packet_out !== 32'h0 || busy !== 1'b0 || pkt_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_state got gnt=%b valid=%b pkt=%h busy=%b cnt=%0d exp all zero",
               gnt_out, valid_out, packet_out, busy, pkt_count);
    end
  endtask

  task automatic test_single();
    do_reset();
    set_slice(2, 32'hA5A5_0001);
    req_in = 5'b00100; ready_in = 1'b1;
    tick();
    checks++;
    if (valid_out !== 1'b1 || packet_out !== 32'hA5A5_0001 || gnt_out !== 5'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_send got valid=%b pkt=%h gnt=%b busy=%b exp 1 a5a50001 00000 1",
               valid_out, packet_out, gnt_out, busy);
    end
    tick();
    checks++;
    if (gnt_out !== 5'b00100 || valid_out !== 1'b0 || pkt_count !== 16'd1) begin
      errors++;
      $display("FAIL single_grant got gnt=%b valid=%b cnt=%0d exp 00100 0 1", gnt_out, valid_out, pkt_count);
    end
    req_in = '0;
    tick();
    checks++;
    if (gnt_out !== 5'b0 || busy !== 1'b0 || pkt_count !== 16'd1) begin
      errors++;
      $display("FAIL single_idle got gnt=%b busy=%b cnt=%0d exp 00000 0 1", gnt_out, busy, pkt_count);
    end
  endtask

  task automatic test_round_robin();
    logic [NP-1:0] exp_gnt;
    logic          exp_valid;
    logic [DW-1:0] exp_pkt;
    int unsigned   p;
    do_reset();
    for (int i = 0; i < NP; i++) set_slice(i, 32'h1000_0000 + 32'(i));
    req_in = 5'b11111; ready_in = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      tick();
      p = 32'(c / 3) % NP;
      exp_gnt   = (c % 3 == 2) ? (5'b00001 << p) : 5'b0;
      exp_valid = (c % 3 == 1);
      exp_pkt   = 32'h1000_0000 + 32'(p);
      checks++;
      if (gnt_out !== exp_gnt || valid_out !== exp_valid || (exp_valid && packet_out !== exp_pkt)) begin
        errors++;
        $display("FAIL rr_cycle%0d got gnt=%b valid=%b pkt=%h exp gnt=%b valid=%b pkt=%h",
                 c, gnt_out, valid_out, packet_out, exp_gnt, exp_valid, exp_pkt);
      end
    end
    checks++;
    if (pkt_count !== 16'd6) begin
      errors++;
      $display("FAIL rr_count got %0d exp 6", pkt_count);
    end
    req_in = '0;
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    set_slice(1, 32'hDEAD_0001);
    req_in = 5'b00010; ready_in = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      set_slice(1, 32'hBEEF_0000 + 32'(i));
      req_in = (i % 2 == 0) ? 5'b00000 : 5'b11111;
      tick();
      checks++;
      if (valid_out !== 1'b1 || packet_out !== 32'hDEAD_0001 || gnt_out !== 5'b0) begin
        errors++;
        $display("FAIL bp_hold%0d got valid=%b pkt=%h gnt=%b exp 1 dead0001 00000",
                 i, valid_out, packet_out, gnt_out);
      end
    end
    ready_in = 1'b1;
    tick();
    checks++;
    if (gnt_out !== 5'b00010 || valid_out !== 1'b0 || pkt_count !== 16'd1) begin
      errors++;
      $display("FAIL bp_grant got gnt=%b valid=%b cnt=%0d exp 00010 0 1", gnt_out, valid_out, pkt_count);
    end
    req_in = '0;
    tick();
    checks++;
    if (gnt_out !== 5'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got gnt=%b busy=%b exp 00000 0", gnt_out, busy);
    end
  endtask

  task automatic test_pointer_move();
    do_reset();
    for (int i = 0; i < NP; i++) set_slice(i, 32'h2000_0000 + 32'(i));
    req_in = 5'b01000; ready_in = 1'b1;
    tick(); tick();
    checks++;
    if (gnt_out !== 5'b01000) begin
      errors++;
      $display("FAIL ptr_first got gnt=%b exp 01000", gnt_out);
    end
    req_in = 5'b10001;
    tick(); tick();
    checks++;
    if (valid_out !== 1'b1 || packet_out !== 32'h2000_0004) begin
      errors++;
      $display("FAIL ptr_send4 got valid=%b pkt=%h exp 1 20000004", valid_out, packet_out);
    end
    tick();
    checks++;
    if (gnt_out !== 5'b10000) begin
      errors++;
      $display("FAIL ptr_wins4 got gnt=%b exp 10000", gnt_out);
    end
    req_in = 5'b00001;
    tick(); tick(); tick();
    checks++;
    if (gnt_out !== 5'b00001) begin
      errors++;
      $display("FAIL ptr_then0 got gnt=%b exp 00001", gnt_out);
    end
    req_in = '0;
    tick();
  endtask

  task automatic test_reset_mid_send();
    do_reset();
    set_slice(2, 32'h3333_0002);
    req_in = 5'b00100; ready_in = 1'b1;
    tick(); tick();
    req_in = '0;
    tick();
    set_slice(3, 32'h3333_0003);
    req_in = 5'b01000; ready_in = 1'b0;
    tick();
    checks++;
    if (valid_out !== 1'b1 || pkt_count !== 16'd1) begin
      errors++;
      $display("FAIL abort_setup got valid=%b cnt=%0d exp 1 1", valid_out, pkt_count);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (valid_out !== 1'b0 || gnt_out !== 5'b0 || pkt_count !== 16'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset got valid=%b gnt=%b cnt=%0d busy=%b exp 0 00000 0 0",
               valid_out, gnt_out, pkt_count, busy);
    end
    req_in = '0; ready_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (gnt_out !== 5'b0) begin
        errors++;
        $display("FAIL abort_nogrant%0d got gnt=%b exp 00000", i, gnt_out);
      end
    end
    req_in = 5'b11111;
    tick(); tick();
    checks++;
    if (gnt_out !== 5'b00001) begin
      errors++;
      $display("FAIL abort_ptr0 got gnt=%b exp 00001", gnt_out);
    end
    req_in = '0;
    tick();
  endtask

  task automatic test_counter_wrap();
    do_reset();
    set_slice(0, 32'h4444_0000);
    req_in = 5'b00001; ready_in = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick(); tick();
      checks++;
      if (pkt_count !== 16'(t) || s_pkt_count !== 3'(t) || s_gnt_out !== 5'b00001) begin
        errors++;
        $display("FAIL wrap_count%0d got cnt=%0d small=%0d sgnt=%b exp %0d %0d 00001",
                 t, pkt_count, s_pkt_count, s_gnt_out, t, t % 8);
      end
      tick();
    end
    checks++;
    if (s_pkt_count !== 3'd0) begin
      errors++;
      $display("FAIL wrap_zero got %0d exp 0", s_pkt_count);
    end
    req_in = '0;
    tick();
  endtask

  initial begin
    reset = 1'b1; req_in = '0; ready_in = 1'b0; packet_in = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_pointer_move();
    test_reset_mid_send();
    test_counter_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
